pc_stack_sequencer: RTL and testbench
=====================================

# pc_stack_sequencer

Multi-cycle control sequencer that drives the execute-memory stage through two-slot PC save/restore on the stack for CALL, RET, RTI and external interrupts. It sits between decode and the execute-memory stage. It issues the push-PC / pop-PC micro-operations and the hazard-state half-select that the execute-memory stage consumes. While a sequence runs, it freezes fetch and decode.

## Interface
- SYNC_STAGES, 2: interrupt-pin synchronizer depth (≥2).
- i_clk  in  1  system clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_call  in  1  decoded CALL in decode, valid this cycle.
- i_ret  in  1  decoded RET.
- i_rti  in  1  decoded RTI.
- i_flush  in  1  execute-memory branch taken this cycle; the decode-slot instruction is wrong-path.
- i_interrupt  in  1  external interrupt pin, asynchronous, level.
- o_push_pc  out  1  execute-memory writes PC half instead of register data.
- o_pop_pc  out  1  execute-memory reads PC half from stack.
- o_branch_flags  out  1  flags travel with the PC (INT push / RTI pop).
- o_hazard_state  out  1  0 = first slot, 1 = second slot of a sequence.
- o_stack_operation  out  1  stack pointer update enable.
- o_stack_function  out  1  1 push, 0 pop.
- o_mem_read  out  1  data-memory read enable.
- o_mem_write  out  1  data-memory write enable.
- o_branch_uncond  out  1  unconditional branch request (CALL target jump).
- o_pc_load  out  1  take restored PC from execute-memory.
- o_int_vector_load  out  1  PC loads the interrupt vector.
- o_stall  out  1  freeze PC and the fetch/decode buffer.
- o_int_ack  out  1  one-cycle pulse when an interrupt is accepted.

## Operation
- States: IDLE, PUSH0, PUSH1, POP0, POP1, VECTOR. All outputs are Moore, decoded from registered state.
- Reset: state = IDLE, interrupt pending = 0, synchronizer cleared. All outputs 0.
- IDLE, priority order:
  - i_flush drops any call/ret/rti.
  - Otherwise i_call or a pending interrupt → PUSH0.
  - Otherwise i_ret or i_rti → POP0.
  - CALL and pending interrupt in the same cycle: CALL wins and the interrupt stays pending.
- Per-state outputs (unlisted outputs are 0):
  - PUSH0: push_pc, stack_operation, stack_function, mem_write, stall, hazard_state = 0. branch_uncond = 1 only if CALL. branch_flags = 1 if INT. Next state PUSH1.
  - PUSH1: same outputs with hazard_state = 1 and branch_uncond = 0. Next state is IDLE for CALL, VECTOR for INT.
  - VECTOR: int_vector_load, stall. Next state IDLE.
  - POP0: pop_pc, stack_operation, mem_read, stall, stack_function = 0, hazard_state = 0. Next state POP1.
  - POP1: same outputs with hazard_state = 1, pc_load = 1, branch_flags = 1 if RTI. Next state IDLE.
- Push order is high half (flags in [15:13] for INT), then low half. Pop order is low half, then high half.
- Source kind (CALL/INT/RET/RTI) is latched on leaving IDLE and held until return to IDLE.
- Interrupt path:
  - SYNC_STAGES flop synchronizer, then rising-edge detect, sets pending.
  - Pending clears when the FSM enters PUSH0 for the interrupt. o_int_ack pulses that same cycle.
  - A further edge while pending or in service is merged; there is no queue depth.
- i_call/i_ret/i_rti are ignored outside IDLE. Decode holds them because o_stall freezes the buffer.

## Timing
- Request sampled at edge N in IDLE. First slot outputs are valid in cycle N+1, second slot in N+2.
- CALL and RET/RTI: back to IDLE in N+3, stall high for 2 cycles.
- INT: VECTOR in N+3, IDLE in N+4, stall high for 3 cycles.
- Interrupt latency from pin edge to PUSH0 is SYNC_STAGES+2 cycles when IDLE with no competing request.
- Back-to-back sequences: a request present in the IDLE cycle after completion starts immediately; there is no dead cycle beyond that IDLE cycle.
- Asynchronous reset mid-sequence forces IDLE and all outputs 0 immediately. A partial push is abandoned; the stack pointer is reset by its own reset.

## Structure
- Shared package holds the state enum (3-bit encoding) and the source-kind enum (CALL, INT, RET, RTI).
- Sub-module int_sync: the synchronizer plus edge detector, parameterized by SYNC_STAGES.

## Test plan
- Reset low mid-PUSH1 → all outputs 0 that cycle; after release state is IDLE and o_stall = 0.
- i_call one cycle in IDLE → cycle+1: push_pc=1, hazard=0, branch_uncond=1, mem_write=1. Cycle+2: hazard=1, branch_uncond=0. Cycle+3: all 0.
- i_rti → POP0 (pop_pc=1, mem_read=1, hazard=0), then POP1 (hazard=1, pc_load=1, branch_flags=1), then IDLE. A plain i_ret gives the same sequence with branch_flags=0 throughout.
- i_interrupt rising edge with SYNC_STAGES=2 while IDLE:
  - int_ack and PUSH0 (branch_flags=1) 4 cycles after the edge.
  - Then PUSH1, then int_vector_load for exactly one cycle.
- i_call and a pending interrupt together → CALL sequence first, then IDLE for one cycle, then INT sequence. A second pin edge during the CALL sequence yields only one INT sequence.
- i_ret with i_flush=1 in IDLE → no state change, all outputs stay 0.

Source files
------------

// File: rtl/pc_stack_sequencer_pkg.sv
// Shared types for the PC save/restore sequencer: FSM states, source kinds
// and the bundle of control strobes sent to the execute-memory stage.
package pc_stack_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PUSH0  = 3'd1,
    PUSH1  = 3'd2,
    POP0   = 3'd3,
    POP1   = 3'd4,
    VECTOR = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    KIND_CALL = 2'd0,
    KIND_INT  = 2'd1,
    KIND_RET  = 2'd2,
    KIND_RTI  = 2'd3
  } kind_t;

  typedef struct packed {
    logic push_pc;
    logic pop_pc;
    logic branch_flags;
    logic hazard_state;
    logic stack_operation;
    logic stack_function;
    logic mem_read;
    logic mem_write;
    logic branch_uncond;
    logic pc_load;
    logic int_vector_load;
    logic stall;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Moore decode: what the execute-memory stage sees while in a given state.
  function automatic ctrl_t decode_ctrl(input state_t state, input kind_t kind);
    ctrl_t c;
    c = CTRL_NONE;
    case (state)
      PUSH0, PUSH1: begin
        c.push_pc         = 1'b1;
        c.stack_operation = 1'b1;
        c.stack_function  = 1'b1;
        c.mem_write       = 1'b1;
        c.stall           = 1'b1;
        c.hazard_state    = (state == PUSH1);
        c.branch_uncond   = (state == PUSH0) && (kind == KIND_CALL);
        c.branch_flags    = (kind == KIND_INT);
      end
      POP0, POP1: begin
        c.pop_pc          = 1'b1;
        c.stack_operation = 1'b1;
        c.mem_read        = 1'b1;
        c.stall           = 1'b1;
        c.hazard_state    = (state == POP1);
        c.pc_load         = (state == POP1);
        // Flags live in the high half, which is popped second.
        c.branch_flags    = (state == POP1) && (kind == KIND_RTI);
      end
      VECTOR: begin
        c.int_vector_load = 1'b1;
        c.stall           = 1'b1;
      end
      default: c = CTRL_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pc_stack_sequencer_int_sync.sv
// Interrupt pin synchronizer followed by a rising-edge detector; rise is a
// single-cycle pulse in the clock domain.
module int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      last  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      last  <= chain[SYNC_STAGES-1];
    end
  end

  assign rise = chain[SYNC_STAGES-1] & ~last;

endmodule

// File: rtl/pc_stack_sequencer.sv
// Multi-cycle CALL/RET/RTI/interrupt sequencer that drives two-slot PC
// push/pop through the execute-memory stage while freezing fetch/decode.
module pc_stack_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_call,
  input  logic i_ret,
  input  logic i_rti,
  input  logic i_flush,
  input  logic i_interrupt,
  output logic o_push_pc,
  output logic o_pop_pc,
  output logic o_branch_flags,
  output logic o_hazard_state,
  output logic o_stack_operation,
  output logic o_stack_function,
  output logic o_mem_read,
  output logic o_mem_write,
  output logic o_branch_uncond,
  output logic o_pc_load,
  output logic o_int_vector_load,
  output logic o_stall,
  output logic o_int_ack
);

  import pc_stack_sequencer_pkg::*;

  state_t state;
  state_t state_next;
  kind_t  kind;
  kind_t  kind_next;
  ctrl_t  ctrl;
  logic   int_rise;
  logic   pending;
  logic   take_int;
  logic   in_service;
  logic   int_ack;

  int_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_int_sync (
    .clk  (i_clk),
    .rst_n(i_reset),
    .pin  (i_interrupt),
    .rise (int_rise)
  );

  // A flush in IDLE means the decode slot is wrong-path, so nothing starts.
  always_comb begin
    state_next = state;
    kind_next  = kind;
    take_int   = 1'b0;
    case (state)
      IDLE: begin
        if (!i_flush) begin
          if (i_call) begin
            state_next = PUSH0;
            kind_next  = KIND_CALL;
          end else if (pending) begin
            state_next = PUSH0;
            kind_next  = KIND_INT;
            take_int   = 1'b1;
          end else if (i_ret) begin
            state_next = POP0;
            kind_next  = KIND_RET;
          end else if (i_rti) begin
            state_next = POP0;
            kind_next  = KIND_RTI;
          end
        end
      end
      PUSH0:   state_next = PUSH1;
      PUSH1:   state_next = (kind == KIND_INT) ? VECTOR : IDLE;
      VECTOR:  state_next = IDLE;
      POP0:    state_next = POP1;
      POP1:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_service = (state != IDLE) && (kind == KIND_INT);

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= IDLE;
      kind    <= KIND_CALL;
      ctrl    <= CTRL_NONE;
      int_ack <= 1'b0;
      pending <= 1'b0;
    end else begin
      state   <= state_next;
      kind    <= kind_next;
      ctrl    <= decode_ctrl(state_next, kind_next);
      int_ack <= take_int;
      if (take_int) begin
        pending <= 1'b0;
      end else if (int_rise && !in_service) begin
        pending <= 1'b1;
      end
    end
  end

  assign o_push_pc         = ctrl.push_pc;
  assign o_pop_pc          = ctrl.pop_pc;
  assign o_branch_flags    = ctrl.branch_flags;
  assign o_hazard_state    = ctrl.hazard_state;
  assign o_stack_operation = ctrl.stack_operation;
  assign o_stack_function  = ctrl.stack_function;
  assign o_mem_read        = ctrl.mem_read;
  assign o_mem_write       = ctrl.mem_write;
  assign o_branch_uncond   = ctrl.branch_uncond;
  assign o_pc_load         = ctrl.pc_load;
  assign o_int_vector_load = ctrl.int_vector_load;
  assign o_stall           = ctrl.stall;
  assign o_int_ack         = int_ack;

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Directed scoreboard bench for pc_stack_sequencer: each step queues the
// expected output vector and checks it one clock later.
module tb_pc_stack_sequencer;

  localparam logic [12:0] B_PUSH  = 13'h1000;
  localparam logic [12:0] B_POP   = 13'h0800;
  localparam logic [12:0] B_FLAGS = 13'h0400;
  localparam logic [12:0] B_HAZ   = 13'h0200;
  localparam logic [12:0] B_SOP   = 13'h0100;
  localparam logic [12:0] B_SFN   = 13'h0080;
  localparam logic [12:0] B_MRD   = 13'h0040;
  localparam logic [12:0] B_MWR   = 13'h0020;
  localparam logic [12:0] B_UNC   = 13'h0010;
  localparam logic [12:0] B_PCL   = 13'h0008;
  localparam logic [12:0] B_VEC   = 13'h0004;
  localparam logic [12:0] B_STL   = 13'h0002;
  localparam logic [12:0] B_ACK   = 13'h0001;

  localparam logic [12:0] ZERO  = 13'h0000;
  localparam logic [12:0] CALL0 = B_PUSH | B_SOP | B_SFN | B_MWR | B_STL | B_UNC;
  localparam logic [12:0] CALL1 = B_PUSH | B_SOP | B_SFN | B_MWR | B_STL | B_HAZ;
  localparam logic [12:0] INT0  = B_PUSH | B_SOP | B_SFN | B_MWR | B_STL | B_FLAGS | B_ACK;
  localparam logic [12:0] INT1  = B_PUSH | B_SOP | B_SFN | B_MWR | B_STL | B_FLAGS | B_HAZ;
  localparam logic [12:0] VEC   = B_VEC | B_STL;
  localparam logic [12:0] RET0  = B_POP | B_SOP | B_MRD | B_STL;
  localparam logic [12:0] RET1  = B_POP | B_SOP | B_MRD | B_STL | B_HAZ | B_PCL;
  localparam logic [12:0] RTI1  = B_POP | B_SOP | B_MRD | B_STL | B_HAZ | B_PCL | B_FLAGS;

  logic i_clk = 1'b0;
  logic i_reset, i_call, i_ret, i_rti, i_flush, i_interrupt;
  logic o_push_pc, o_pop_pc, o_branch_flags, o_hazard_state, o_stack_operation;
  logic o_stack_function, o_mem_read, o_mem_write, o_branch_uncond, o_pc_load;
  logic o_int_vector_load, o_stall, o_int_ack;
  logic [12:0] observed;
  logic [12:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  pc_stack_sequencer #(.SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_call(i_call), .i_ret(i_ret),
    .i_rti(i_rti), .i_flush(i_flush), .i_interrupt(i_interrupt),
    .o_push_pc(o_push_pc), .o_pop_pc(o_pop_pc), .o_branch_flags(o_branch_flags),
    .o_hazard_state(o_hazard_state), .o_stack_operation(o_stack_operation),
    .o_stack_function(o_stack_function), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_branch_uncond(o_branch_uncond),
    .o_pc_load(o_pc_load), .o_int_vector_load(o_int_vector_load),
    .o_stall(o_stall), .o_int_ack(o_int_ack)
  );

  always #5 i_clk = ~i_clk;

  assign observed = {o_push_pc, o_pop_pc, o_branch_flags, o_hazard_state,
                     o_stack_operation, o_stack_function, o_mem_read, o_mem_write,
                     o_branch_uncond, o_pc_load, o_int_vector_load, o_stall, o_int_ack};

  task automatic checkOutput(input string tag);
    logic [12:0] expected;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL %s: scoreboard empty, observed %h", tag, observed);
    end else begin
      expected = exp_q.pop_front();
      assert (observed === expected) else begin
        fails++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
    end
  endtask

  task automatic applyStimulus(input logic [12:0] expected, input string tag);
    exp_q.push_back(expected);
    @(posedge i_clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    i_reset = 1'b0; i_call = 1'b0; i_ret = 1'b0; i_rti = 1'b0;
    i_flush = 1'b0; i_interrupt = 1'b0;
    #12;
    exp_q.push_back(ZERO);
    checkOutput("reset_state");
    i_reset = 1'b1;
    applyStimulus(ZERO, "idle_after_reset");

    // CALL sequence
    i_call = 1'b1;
    applyStimulus(CALL0, "call_push0");
    i_call = 1'b0;
    applyStimulus(CALL1, "call_push1");
    applyStimulus(ZERO, "call_done");

    // RTI and RET sequences
    i_rti = 1'b1;
    applyStimulus(RET0, "rti_pop0");
    i_rti = 1'b0;
    applyStimulus(RTI1, "rti_pop1");
    applyStimulus(ZERO, "rti_done");
    i_ret = 1'b1;
    applyStimulus(RET0, "ret_pop0");
    i_ret = 1'b0;
    applyStimulus(RET1, "ret_pop1");
    applyStimulus(ZERO, "ret_done");

    // Flushed RET is dropped
    i_ret = 1'b1; i_flush = 1'b1;
    applyStimulus(ZERO, "flush_ret");
    i_ret = 1'b0; i_flush = 1'b0;
    applyStimulus(ZERO, "flush_idle");

    // Interrupt latency: pin edge to PUSH0 in 4 cycles
    i_interrupt = 1'b1;
    applyStimulus(ZERO, "int_lat1");
    applyStimulus(ZERO, "int_lat2");
    applyStimulus(ZERO, "int_lat3");
    applyStimulus(INT0, "int_push0");
    i_interrupt = 1'b0;
    applyStimulus(INT1, "int_push1");
    applyStimulus(VEC, "int_vector");
    applyStimulus(ZERO, "int_done");
    applyStimulus(ZERO, "int_quiet");

    // CALL competes with a pending interrupt; second edge during CALL merges
    i_interrupt = 1'b1;
    applyStimulus(ZERO, "mix_e1");
    applyStimulus(ZERO, "mix_e2");
    i_interrupt = 1'b0;
    applyStimulus(ZERO, "mix_pending");
    i_call = 1'b1;
    applyStimulus(CALL0, "mix_call_push0");
    i_call = 1'b0; i_interrupt = 1'b1;
    applyStimulus(CALL1, "mix_call_push1");
    applyStimulus(ZERO, "mix_idle_gap");
    applyStimulus(INT0, "mix_int_push0");
    applyStimulus(INT1, "mix_int_push1");
    applyStimulus(VEC, "mix_int_vector");
    i_interrupt = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(ZERO, "mix_no_second_int");

    // Back-to-back RET and RTI with the request held
    i_ret = 1'b1;
    applyStimulus(RET0, "b2b_ret_a0");
    applyStimulus(RET1, "b2b_ret_a1");
    applyStimulus(ZERO, "b2b_ret_idle");
    applyStimulus(RET0, "b2b_ret_b0");
    i_ret = 1'b0;
    applyStimulus(RET1, "b2b_ret_b1");
    applyStimulus(ZERO, "b2b_ret_done");
    i_rti = 1'b1;
    applyStimulus(RET0, "b2b_rti_a0");
    applyStimulus(RTI1, "b2b_rti_a1");
    applyStimulus(ZERO, "b2b_rti_idle");
    applyStimulus(RET0, "b2b_rti_b0");
    i_rti = 1'b0;
    applyStimulus(RTI1, "b2b_rti_b1");
    applyStimulus(ZERO, "b2b_rti_done");

    // Asynchronous reset in the middle of PUSH1
    i_call = 1'b1;
    applyStimulus(CALL0, "rst_call_push0");
    i_call = 1'b0;
    applyStimulus(CALL1, "rst_call_push1");
    #2 i_reset = 1'b0;
    #1;
    exp_q.push_back(ZERO);
    checkOutput("rst_mid_push1");
    #1 i_reset = 1'b1;
    applyStimulus(ZERO, "rst_released_idle");
    i_ret = 1'b1;
    applyStimulus(RET0, "rst_then_ret0");
    i_ret = 1'b0;
    applyStimulus(RET1, "rst_then_ret1");
    applyStimulus(ZERO, "rst_then_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
